// File: rtl/keypair_byte_streamer.sv
// Streams a finished keypair out one byte per valid/ready transfer: public key first, then secret key.
// Key buses are read in place through a counter-indexed byte mux; the source holds them while busy.
module keypair_byte_streamer #(
  parameter int PK_BYTES = 1952,
  parameter int SK_BYTES = 3648,
  parameter int CNT_W    = 13
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rtr,
  input  logic [8*PK_BYTES-1:0]   linear_pk,
  input  logic [8*SK_BYTES-1:0]   linear_sk,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    out_sel,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int PK_IW = (PK_BYTES > 1) ? $clog2(PK_BYTES) : 1;
  localparam int SK_IW = (SK_BYTES > 1) ? $clog2(SK_BYTES) : 1;
  localparam logic [CNT_W-1:0] PK_LAST = CNT_W'(PK_BYTES - 1);
  localparam logic [CNT_W-1:0] SK_LAST = CNT_W'(SK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND_PK, SEND_SK, DONE} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               count;
  logic [CNT_W-1:0]               count_nxt;
  logic [PK_BYTES-1:0][7:0]       pk_bytes;
  logic [SK_BYTES-1:0][7:0]       sk_bytes;

  assign pk_bytes  = linear_pk;
  assign sk_bytes  = linear_sk;
  assign count_nxt = count + CNT_W'(1);

  // The next byte is fetched on the accepting edge, so out_data is always registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (rtr) begin
            state     <= SEND_PK;
            count     <= '0;
            out_valid <= 1'b1;
            out_data  <= pk_bytes[0];
            out_sel   <= 1'b0;
            out_last  <= (PK_BYTES == 1);
            busy      <= 1'b1;
          end
        end
        SEND_PK: begin
          if (out_ready) begin
            if (count == PK_LAST) begin
              state    <= SEND_SK;
              count    <= '0;
              out_sel  <= 1'b1;
              out_data <= sk_bytes[0];
              out_last <= (SK_BYTES == 1);
            end else begin
              count    <= count_nxt;
              out_data <= pk_bytes[count_nxt[PK_IW-1:0]];
              out_last <= (count_nxt == PK_LAST);
            end
          end
        end
        SEND_SK: begin
          if (out_ready) begin
            if (count == SK_LAST) begin
              state     <= DONE;
              count     <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_sel   <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              count    <= count_nxt;
              out_data <= sk_bytes[count_nxt[SK_IW-1:0]];
              out_last <= (count_nxt == SK_LAST);
            end
          end
        end
        DONE: begin
          // A held-high rtr must not restart the stream; wait for it to drop first.
          if (!rtr) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypair_byte_streamer.sv
// Directed bench for keypair_byte_streamer: pk byte i = i[7:0], sk byte j = ~j[7:0].
module tb_keypair_byte_streamer;

  localparam int PK_BYTES = 1952;
  localparam int SK_BYTES = 3648;
  localparam int TOTAL    = PK_BYTES + SK_BYTES;

  logic                  clock;
  logic                  reset;
  logic                  rtr;
  logic [8*PK_BYTES-1:0] linear_pk;
  logic [8*SK_BYTES-1:0] linear_sk;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic                  out_sel;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  int total;
  int bad;

  keypair_byte_streamer #(
    .PK_BYTES(PK_BYTES),
    .SK_BYTES(SK_BYTES),
    .CNT_W   (13)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rtr      (rtr),
    .linear_pk(linear_pk),
    .linear_sk(linear_sk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {valid,busy,done,sel,last,data} while byte n of the combined stream is presented.
  function automatic logic [12:0] exp_beat(input int n);
    int j;
    if (n < PK_BYTES) return {3'b110, 1'b0, (n == PK_BYTES - 1), 8'(n)};
    j = n - PK_BYTES;
    return {3'b110, 1'b1, (j == SK_BYTES - 1), ~8'(j)};
  endfunction

  function automatic logic [12:0] obs_beat();
    return {out_valid, busy, done, out_sel, out_last, out_data};
  endfunction

  // Entered at a falling edge where byte 0 should be on the bus. Checks every cycle,
  // including stalls, so a held byte that changes is caught. Returns early at stop_at.
  task automatic stream(input bit rnd, input int drop_at, input int stop_at);
    int  n;
    int  cyc;
    logic rdy;
    n   = 0;
    cyc = 0;
    while (n < TOTAL) begin
      if (n == stop_at) return;
      if (cyc >= 20000) begin
        chk("stream_timeout", 32'(n), 32'(TOTAL));
        return;
      end
      chk("beat", 32'(obs_beat()), 32'(exp_beat(n)));
      rdy       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      rtr       = (n == drop_at) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (rdy) n++;
      cyc++;
    end
    rtr = 1'b1;
    chk("done_after_last", 32'({out_valid, busy, done}), 32'(3'b001));
  endtask

  task automatic restart();
    rtr = 1'b0;
    @(negedge clock);
    chk("idle_after_drop", 32'({out_valid, busy, done}), 32'(3'b000));
    rtr = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    rtr       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < PK_BYTES; i++) linear_pk[8*i +: 8] = 8'(i);
    for (int j = 0; j < SK_BYTES; j++) linear_sk[8*j +: 8] = ~8'(j);

    // reset held with rtr high: everything stays quiet
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("reset_outputs", 32'(obs_beat()), 32'(0));
    end
    reset = 1'b0;
    @(negedge clock);

    // full-rate stream
    stream(1'b0, -1, -1);

    // rtr held high after done: no restart, ready while invalid is ignored
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("done_hold", 32'({out_valid, busy, done}), 32'(3'b001));
    end

    // drop rtr, idle a few cycles with ready high, then a random-stall stream
    rtr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("idle_ready_ignored", 32'({out_valid, busy, done}), 32'(3'b000));
    end
    rtr = 1'b1;
    @(negedge clock);
    stream(1'b1, -1, -1);

    // rtr dropped while pk byte 500 is presented: stream must not break
    restart();
    stream(1'b0, 500, -1);

    // reset while sk byte 100 is on the bus, then restart from pk byte 0
    restart();
    stream(1'b0, -1, PK_BYTES + 100);
    chk("sk100_before_reset", 32'(obs_beat()), 32'(exp_beat(PK_BYTES + 100)));
    reset = 1'b1;
    @(negedge clock);
    chk("midstream_reset", 32'(obs_beat()), 32'(0));
    reset = 1'b0;
    @(negedge clock);
    stream(1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
